// File: rtl/bitfusion_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bitfusion_pkg
// Description : Weight-bitwidth mode encodings and hold-length helper shared
//               by the BitFusion input path.
// Revision    : 1.0 - initial release
// ============================================================================
package bitfusion_pkg;

  localparam logic [1:0] BW_8B   = 2'b00;
  localparam logic [1:0] BW_4B   = 2'b01;
  localparam logic [1:0] BW_2B   = 2'b10;
  localparam logic [1:0] BW_RSVD = 2'b11;

  // Number of cycles a word is presented for the given mode; 0 means unusable.
  function automatic logic [2:0] hold_len(input logic [1:0] mode);
    case (mode)
      BW_8B:   hold_len = 3'd1;
      BW_4B:   hold_len = 3'd2;
      BW_2B:   hold_len = 3'd4;
      default: hold_len = 3'd0;
    endcase
  endfunction

endpackage : bitfusion_pkg
`default_nettype wire

// File: rtl/input_word_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : input_word_sequencer_if
// Description : Upstream word handshake plus the phased buffer presentation
//               toward the input mux.
// Revision    : 1.0 - initial release
// ============================================================================
interface input_word_sequencer_if;

  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_ready;
  logic [31:0] buffer;
  logic        buffer_valid;
  logic [1:0]  phase;
  logic        last_phase;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, buffer, buffer_valid, phase, last_phase
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, buffer, buffer_valid, phase, last_phase
  );

endinterface : input_word_sequencer_if
`default_nettype wire

// File: rtl/input_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : input_word_fifo
// Description : Synchronous FIFO with wrap-bit pointers and registered count.
// Revision    : 1.0 - initial release
// ============================================================================
module input_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] wdata,
  output logic      [WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic      [CNT_W-1:0] count
);

  localparam int                c_addr_w  = $clog2(DEPTH);
  localparam logic [c_addr_w:0] c_ptr_one = {{c_addr_w{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [c_addr_w:0] r_wptr;
  logic [c_addr_w:0] r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign full  = (r_wptr[c_addr_w] != r_rptr[c_addr_w]) &&
                 (r_wptr[c_addr_w-1:0] == r_rptr[c_addr_w-1:0]);
  assign empty = (r_wptr == r_rptr);
  assign rdata = r_mem[r_rptr[c_addr_w-1:0]];
  assign count = r_count;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[c_addr_w-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : input_word_fifo
`default_nettype wire

// File: rtl/input_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : input_word_sequencer
// Description : Queues activation words and presents each one for 1/2/4
//               phases according to the latched weight bitwidth.
// Revision    : 1.0 - initial release
// ============================================================================
module input_word_sequencer
  import bitfusion_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic [1:0]            weight_bitwidth,
  input_word_sequencer_if.slave      bus,
  output logic      [CNT_W-1:0]      fifo_count
);

  logic [31:0] r_buffer;
  logic        r_buffer_valid;
  logic [1:0]  r_phase;
  logic [1:0]  r_mode;

  logic [31:0] w_fifo_rdata;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_push;
  logic [2:0]  w_hold;
  logic        w_last_phase;
  logic        w_load;

  input_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_load),
    .wdata (bus.in_data),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (fifo_count)
  );

  assign w_push       = bus.in_valid && !w_fifo_full;
  assign w_hold       = hold_len(r_mode);
  assign w_last_phase = r_buffer_valid && ({1'b0, r_phase} == (w_hold - 3'd1));

  // Reserved mode blocks loading so the queue simply fills until a legal mode returns.
  assign w_load = (!r_buffer_valid || (w_last_phase && bus.out_ready)) &&
                  !w_fifo_empty && (weight_bitwidth != BW_RSVD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buffer       <= '0;
      r_buffer_valid <= 1'b0;
      r_phase        <= '0;
      r_mode         <= BW_8B;
    end else if (w_load) begin
      r_buffer       <= w_fifo_rdata;
      r_buffer_valid <= 1'b1;
      r_phase        <= '0;
      r_mode         <= weight_bitwidth;
    end else if (r_buffer_valid && bus.out_ready) begin
      if (w_last_phase) begin
        r_buffer_valid <= 1'b0;
        r_phase        <= '0;
      end else begin
        r_phase <= r_phase + 2'd1;
      end
    end
  end

  assign bus.in_ready     = !w_fifo_full;
  assign bus.buffer       = r_buffer;
  assign bus.buffer_valid = r_buffer_valid;
  assign bus.phase        = r_phase;
  assign bus.last_phase   = w_last_phase;

endmodule : input_word_sequencer
`default_nettype wire

// File: tb/tb_input_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_word_sequencer
// Description : Scenario bench with a word scoreboard for input_word_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_word_sequencer;
  import bitfusion_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       weight_bitwidth;
  logic [CNT_W-1:0] fifo_count;

  input_word_sequencer_if bus ();

  input_word_sequencer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .weight_bitwidth (weight_bitwidth),
    .bus             (bus),
    .fifo_count      (fifo_count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_w;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    exp_q.push_back(d);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_exp();
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    total++; if (bus.buffer !== 32'h0) begin bad++; $display("FAIL rst_buffer got=%h exp=%h", bus.buffer, 32'h0); end
    total++; if (bus.buffer_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.buffer_valid); end
    total++; if (bus.phase !== 2'd0) begin bad++; $display("FAIL rst_phase got=%0d exp=0", bus.phase); end
    total++; if (bus.last_phase !== 1'b0) begin bad++; $display("FAIL rst_last got=%b exp=0", bus.last_phase); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    reset = 1'b1;
    tick();
    weight_bitwidth = BW_4B;
    bus.out_ready   = 1'b0;
    push(32'hCAFE_0001);
    push(32'hCAFE_0002);
    pop_exp();
    total++; if (bus.buffer_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_valid got=%b exp=1", bus.buffer_valid); end
    total++; if (bus.buffer !== exp_w) begin bad++; $display("FAIL pre_rst_buffer got=%h exp=%h", bus.buffer, exp_w); end
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL pre_rst_count got=%0d exp=1", fifo_count); end
    // Asynchronous assertion away from any clock edge.
    #3 reset = 1'b0;
    #1;
    exp_q.delete();
    total++; if (bus.buffer !== 32'h0) begin bad++; $display("FAIL mid_rst_buffer got=%h exp=%h", bus.buffer, 32'h0); end
    total++; if (bus.buffer_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", bus.buffer_valid); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", fifo_count); end
    total++; if (bus.phase !== 2'd0) begin bad++; $display("FAIL mid_rst_phase got=%0d exp=0", bus.phase); end
    tick();
    reset = 1'b1;
    tick();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.buffer_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b exp=0", bus.buffer_valid); end
  endtask

  task automatic test_stream_8b();
    logic [31:0] w [3];
    w[0] = 32'h1111_1111; w[1] = 32'h2222_2222; w[2] = 32'h3333_3333;
    weight_bitwidth = BW_8B;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_data     = w[0];
    exp_q.push_back(w[0]);
    tick();
    total++; if (bus.buffer_valid !== 1'b0) begin bad++; $display("FAIL s8_latency got=%b exp=0", bus.buffer_valid); end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        bus.in_data = w[i+1];
        exp_q.push_back(w[i+1]);
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      pop_exp();
      total++; if (bus.buffer_valid !== 1'b1) begin bad++; $display("FAIL s8_valid[%0d] got=%b exp=1", i, bus.buffer_valid); end
      total++; if (bus.buffer !== exp_w) begin bad++; $display("FAIL s8_buffer[%0d] got=%h exp=%h", i, bus.buffer, exp_w); end
      total++; if (bus.phase !== 2'd0) begin bad++; $display("FAIL s8_phase[%0d] got=%0d exp=0", i, bus.phase); end
      total++; if (bus.last_phase !== 1'b1) begin bad++; $display("FAIL s8_last[%0d] got=%b exp=1", i, bus.last_phase); end
    end
    tick();
    total++; if (bus.buffer_valid !== 1'b0) begin bad++; $display("FAIL s8_idle_valid got=%b exp=0", bus.buffer_valid); end
    total++; if (bus.buffer !== w[2]) begin bad++; $display("FAIL s8_idle_buffer got=%h exp=%h", bus.buffer, w[2]); end
  endtask

  task automatic test_hold_2b_stall();
    logic [1:0] ph  [7];
    logic       orv [7];
    ph  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
    orv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    weight_bitwidth = BW_2B;
    bus.out_ready   = 1'b1;
    push(32'hA5A5_F00F);
    tick();
    pop_exp();
    for (int i = 0; i < 7; i++) begin
      total++; if (bus.buffer_valid !== 1'b1) begin bad++; $display("FAIL h2_valid[%0d] got=%b exp=1", i, bus.buffer_valid); end
      total++; if (bus.buffer !== exp_w) begin bad++; $display("FAIL h2_buffer[%0d] got=%h exp=%h", i, bus.buffer, exp_w); end
      total++; if (bus.phase !== ph[i]) begin bad++; $display("FAIL h2_phase[%0d] got=%0d exp=%0d", i, bus.phase, ph[i]); end
      total++; if (bus.last_phase !== (i == 6)) begin bad++; $display("FAIL h2_last[%0d] got=%b exp=%b", i, bus.last_phase, (i == 6)); end
      bus.out_ready = orv[i];
      tick();
    end
    total++; if (bus.buffer_valid !== 1'b0) begin bad++; $display("FAIL h2_retire_valid got=%b exp=0", bus.buffer_valid); end
    total++; if (bus.phase !== 2'd0) begin bad++; $display("FAIL h2_retire_phase got=%0d exp=0", bus.phase); end
    total++; if (bus.buffer !== exp_w) begin bad++; $display("FAIL h2_retire_buffer got=%h exp=%h", bus.buffer, exp_w); end
  endtask

  task automatic test_mode_change();
    weight_bitwidth = BW_4B;
    bus.out_ready   = 1'b1;
    push(32'h4444_0001);
    push(32'h8888_0002);
    pop_exp();
    total++; if (bus.buffer !== exp_w) begin bad++; $display("FAIL mc_w1_buffer got=%h exp=%h", bus.buffer, exp_w); end
    total++; if (bus.last_phase !== 1'b0) begin bad++; $display("FAIL mc_w1_p0_last got=%b exp=0", bus.last_phase); end
    weight_bitwidth = BW_8B;
    tick();
    total++; if (bus.buffer !== exp_w) begin bad++; $display("FAIL mc_w1_hold got=%h exp=%h", bus.buffer, exp_w); end
    total++; if (bus.phase !== 2'd1) begin bad++; $display("FAIL mc_w1_phase got=%0d exp=1", bus.phase); end
    total++; if (bus.last_phase !== 1'b1) begin bad++; $display("FAIL mc_w1_p1_last got=%b exp=1", bus.last_phase); end
    tick();
    pop_exp();
    total++; if (bus.buffer !== exp_w) begin bad++; $display("FAIL mc_w2_buffer got=%h exp=%h", bus.buffer, exp_w); end
    total++; if (bus.last_phase !== 1'b1) begin bad++; $display("FAIL mc_w2_last got=%b exp=1", bus.last_phase); end
    tick();
    total++; if (bus.buffer_valid !== 1'b0) begin bad++; $display("FAIL mc_idle_valid got=%b exp=0", bus.buffer_valid); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] w [6];
    for (int i = 0; i < 6; i++) w[i] = 32'hF000_0000 + 32'(i);
    weight_bitwidth = BW_8B;
    bus.out_ready   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w[i];
      total++; if (bus.in_ready !== (i < 5)) begin bad++; $display("FAIL fw_in_ready[%0d] got=%b exp=%b", i, bus.in_ready, (i < 5)); end
      if (i < 5) exp_q.push_back(w[i]);
      tick();
    end
    pop_exp();
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL fw_count_full got=%0d exp=4", fifo_count); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fw_full_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.buffer !== exp_w) begin bad++; $display("FAIL fw_out_reg got=%h exp=%h", bus.buffer, exp_w); end
    tick();
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL fw_held_off got=%0d exp=4", fifo_count); end
    // Pop while full must not let the held word in on the same edge.
    bus.out_ready = 1'b1;
    tick();
    pop_exp();
    total++; if (bus.buffer !== exp_w) begin bad++; $display("FAIL fw_drain0 got=%h exp=%h", bus.buffer, exp_w); end
    total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL fw_pop_full_count got=%0d exp=3", fifo_count); end
    exp_q.push_back(w[5]);
    tick();
    bus.in_valid = 1'b0;
    pop_exp();
    total++; if (bus.buffer !== exp_w) begin bad++; $display("FAIL fw_drain1 got=%h exp=%h", bus.buffer, exp_w); end
    total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL fw_pushpop_count got=%0d exp=3", fifo_count); end
    for (int k = 0; k < 3; k++) begin
      tick();
      pop_exp();
      total++; if (bus.buffer_valid !== 1'b1) begin bad++; $display("FAIL fw_valid[%0d] got=%b exp=1", k, bus.buffer_valid); end
      total++; if (bus.buffer !== exp_w) begin bad++; $display("FAIL fw_order[%0d] got=%h exp=%h", k, bus.buffer, exp_w); end
    end
    tick();
    total++; if (bus.buffer_valid !== 1'b0) begin bad++; $display("FAIL fw_empty_valid got=%b exp=0", bus.buffer_valid); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL fw_empty_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_reserved();
    bus.out_ready   = 1'b1;
    weight_bitwidth = BW_RSVD;
    push(32'h5EED_0001);
    push(32'h5EED_0002);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.buffer_valid !== 1'b0) begin bad++; $display("FAIL rv_valid[%0d] got=%b exp=0", i, bus.buffer_valid); end
    end
    total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL rv_count got=%0d exp=2", fifo_count); end
    weight_bitwidth = BW_8B;
    tick();
    pop_exp();
    total++; if (bus.buffer !== exp_w) begin bad++; $display("FAIL rv_resume0 got=%h exp=%h", bus.buffer, exp_w); end
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL rv_resume_count got=%0d exp=1", fifo_count); end
    tick();
    pop_exp();
    total++; if (bus.buffer !== exp_w) begin bad++; $display("FAIL rv_resume1 got=%h exp=%h", bus.buffer, exp_w); end
    tick();
    total++; if (bus.buffer_valid !== 1'b0) begin bad++; $display("FAIL rv_idle_valid got=%b exp=0", bus.buffer_valid); end
  endtask

  initial begin
    reset           = 1'b0;
    weight_bitwidth = BW_8B;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;
    test_reset();
    test_stream_8b();
    test_hold_2b_stall();
    test_mode_change();
    test_full_wrap();
    test_reserved();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule : tb_input_word_sequencer
`default_nettype wire
